// File: rtl/riscv_pkg.sv
// Shared datapath types and widths for the register file.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0]        regidx_t;

endpackage

// File: rtl/registerbank_readport.sv
// One combinational read port: index -> register contents, x0 reads as zero.
module registerbank_readport
    import riscv_pkg::*;
(
    input  word_t   regs [NUM_REGS],
    input  regidx_t idx,
    output word_t   data_c
);

    // Index mux with the zero-register override.
    always_comb begin
        data_c = '0;
        if (idx != '0) begin
            data_c = regs[idx];
        end
    end

endmodule

// File: rtl/registerbank.sv
// 32 x 32-bit general-purpose register file: two async read ports, one write port.
module registerbank
    import riscv_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    input  regidx_t read_reg1,
    input  regidx_t read_reg2,
    input  regidx_t write_reg,
    input  word_t   write_data,
    input  logic    reg_write,
    output word_t   read_data1,
    output word_t   read_data2
);

    word_t regs [NUM_REGS];

    // Storage: async clear, gated write; index 0 is never loaded so it stays zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (reg_write && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    registerbank_readport u_port1 (
        .regs   (regs),
        .idx    (read_reg1),
        .data_c (read_data1)
    );

    registerbank_readport u_port2 (
        .regs   (regs),
        .idx    (read_reg2),
        .data_c (read_data2)
    );

endmodule

// File: tb/tb_registerbank.sv
// Bench for registerbank: vector table plus hand-written fill/readback and reset sequences.
module tb_registerbank;

    logic        clock;
    logic        reset_n;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        clk_edge;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    localparam int NVEC = 17;
    vec_t        vecs [NVEC];
    exp_t        sb [$];
    logic [31:0] shadow [32];

    registerbank dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare both read ports against it.
    task automatic compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h/%h expected an entry", name, read_data1, read_data2);
        end else begin
            e = sb.pop_front();
            check({name, ".rd1"}, read_data1, e.e1);
            check({name, ".rd2"}, read_data2, e.e2);
        end
    endtask

    // Drive at the falling edge; sample before the next rising edge or 1ns after it.
    // After a no-edge step the enable is dropped so the following rising edge is harmless.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clock);
        reset_n    = v.rst_n;
        reg_write  = v.we;
        write_reg  = v.wr;
        write_data = v.wd;
        read_reg1  = v.r1;
        read_reg2  = v.r2;
        e.e1 = v.e1;
        e.e2 = v.e2;
        sb.push_back(e);
        if (v.clk_edge) begin
            @(posedge clock);
            #1;
        end else begin
            #1;
        end
        compare(name);
        if (!v.clk_edge) reg_write = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        //           rst  we  wr  wd             r1  r2  edge e1             e2
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'd0,        5'd1,  5'd31, 1'b0, 32'd0,        32'd0};
        vecs[1]  = '{1'b1, 1'b1, 5'd1,  32'd14,       5'd1,  5'd0,  1'b0, 32'd0,        32'd0};
        vecs[2]  = '{1'b1, 1'b1, 5'd1,  32'd14,       5'd1,  5'd0,  1'b1, 32'd14,       32'd0};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  32'd24,       5'd1,  5'd3,  1'b1, 32'd14,       32'd24};
        vecs[4]  = '{1'b1, 1'b1, 5'd3,  32'd80,       5'd1,  5'd3,  1'b0, 32'd14,       32'd24};
        vecs[5]  = '{1'b1, 1'b0, 5'd3,  32'd80,       5'd3,  5'd3,  1'b1, 32'd24,       32'd24};
        vecs[6]  = '{1'b1, 1'b1, 5'd0,  32'd14,       5'd0,  5'd1,  1'b1, 32'd0,        32'd14};
        vecs[7]  = '{1'b1, 1'b1, 5'd0,  32'd14,       5'd0,  5'd1,  1'b1, 32'd0,        32'd14};
        vecs[8]  = '{1'b1, 1'b0, 5'd1,  32'd99,       5'd1,  5'd0,  1'b1, 32'd14,       32'd0};
        vecs[9]  = '{1'b1, 1'b0, 5'd1,  32'd99,       5'd1,  5'd0,  1'b1, 32'd14,       32'd0};
        vecs[10] = '{1'b1, 1'b1, 5'd5,  32'hFFFFFFF9, 5'd5,  5'd5,  1'b0, 32'd0,        32'd0};
        vecs[11] = '{1'b1, 1'b1, 5'd5,  32'hFFFFFFF9, 5'd5,  5'd5,  1'b1, 32'hFFFFFFF9, 32'hFFFFFFF9};
        vecs[12] = '{1'b1, 1'b1, 5'd31, 32'h7FFFFFFF, 5'd31, 5'd1,  1'b1, 32'h7FFFFFFF, 32'd14};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'd0,        5'd1,  5'd3,  1'b0, 32'd0,        32'd0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'd0,        5'd5,  5'd31, 1'b0, 32'd0,        32'd0};
        vecs[15] = '{1'b0, 1'b1, 5'd1,  32'd55,       5'd1,  5'd5,  1'b1, 32'd0,        32'd0};
        vecs[16] = '{1'b1, 1'b1, 5'd1,  32'd55,       5'd1,  5'd3,  1'b1, 32'd55,       32'd0};

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Fill every register, tracking expected contents in a shadow model.
        begin
            vec_t v;
            @(negedge clock);
            reset_n = 1'b0;
            #1;
            for (int i = 0; i < 32; i++) shadow[i] = '0;
            for (int i = 1; i < 32; i++) begin
                v.rst_n    = 1'b1;
                v.we       = 1'b1;
                v.wr       = 5'(i);
                v.wd       = (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
                v.r1       = 5'(i);
                v.r2       = 5'(i - 1);
                v.clk_edge = 1'b1;
                shadow[i]  = v.wd;
                v.e1       = shadow[i];
                v.e2       = shadow[i-1];
                apply(v, $sformatf("fill%0d", i));
            end

            // Combinational readback, ports crossing over the whole file.
            for (int i = 0; i < 32; i += 3) begin
                v.rst_n    = 1'b1;
                v.we       = 1'b0;
                v.wr       = 5'(i);
                v.wd       = 32'hDEADBEEF;
                v.r1       = 5'(i);
                v.r2       = 5'(31 - i);
                v.clk_edge = 1'b0;
                v.e1       = shadow[i];
                v.e2       = shadow[31-i];
                apply(v, $sformatf("rdbk%0d", i));
            end

            // Reset between edges clears everything at once.
            @(negedge clock);
            read_reg1 = 5'd31;
            read_reg2 = 5'd17;
            #2;
            reset_n = 1'b0;
            #1;
            check("async_rst.rd1", read_data1, 32'd0);
            check("async_rst.rd2", read_data2, 32'd0);
            for (int i = 1; i < 32; i += 5) begin
                v.rst_n    = 1'b0;
                v.we       = 1'b0;
                v.wr       = 5'd0;
                v.wd       = 32'd0;
                v.r1       = 5'(i);
                v.r2       = 5'(i + 1);
                v.clk_edge = 1'b0;
                v.e1       = 32'd0;
                v.e2       = 32'd0;
                apply(v, $sformatf("rstrd%0d", i));
            end

            // First write after release lands on the next qualifying edge.
            v = '{1'b1, 1'b1, 5'd9, 32'h80000000, 5'd9, 5'd31, 1'b1, 32'h80000000, 32'd0};
            apply(v, "post_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
